// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on refclk: pulses pll_rst, waits for a debounced lock, then releases core_rst.
// Optional lock-loss counter enabled by PLL_RESET_SEQ_RELOCK_CNT_EN; otherwise relock_cnt reads 0.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// HOLD        | pll_rst high for RST_HOLD_CYCLES, core held in reset
// WAIT_LOCK   | pll_rst released, waiting for lk, bounded by LOCK_TIMEOUT_CYCLES
// STABLE      | lk seen, counting LOCK_STABLE_CYCLES consecutive locked cycles
// RUN         | core released; lock loss or soft_restart goes back to HOLD
module pll_reset_sequencer #(
   parameter int RST_HOLD_CYCLES     = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 100000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int CNT_W               = 20
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       soft_restart,
   output logic       pll_rst,
   output logic       core_rst,
   output logic       ready,
   output logic [1:0] state,
   output logic       timeout_err,
   output logic [7:0] relock_cnt
);

   typedef enum logic [1:0] {
      S_HOLD      = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_STABLE    = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

   state_t           cur_state;
   state_t           nxt_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             sync_1;
   logic             lk;
   logic             timeout_hit;

   // pll_locked is asynchronous to refclk
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync_1 <= 1'b0;
         lk     <= 1'b0;
      end else begin
         sync_1 <= pll_locked;
         lk     <= sync_1;
      end
   end

   always_comb begin
      nxt_state   = cur_state;
      timeout_hit = 1'b0;
      case (cur_state)
         S_HOLD: begin
            if (cnt == HOLD_LAST) nxt_state = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (lk) begin
               nxt_state = S_STABLE;
            end else if (cnt == TIMEOUT_LAST) begin
               nxt_state   = S_HOLD;
               timeout_hit = 1'b1;
            end
         end
         S_STABLE: begin
            if (!lk) nxt_state = S_WAIT_LOCK;
            else if (cnt == STABLE_LAST) nxt_state = S_RUN;
         end
         S_RUN: begin
            if (!lk || soft_restart) nxt_state = S_HOLD;
         end
         default: nxt_state = S_HOLD;
      endcase
      cnt_nxt = ((nxt_state != cur_state) || (cur_state == S_RUN)) ? '0 : cnt + CNT_W'(1);
   end

   // Outputs are decoded from the next state so they move with state
   always_ff @(posedge refclk) begin
      if (rst) begin
         cur_state   <= S_HOLD;
         cnt         <= '0;
         pll_rst     <= 1'b1;
         core_rst    <= 1'b1;
         ready       <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         cnt       <= cnt_nxt;
         pll_rst   <= (nxt_state == S_HOLD);
         core_rst  <= (nxt_state != S_RUN);
         ready     <= (nxt_state == S_RUN);
         if (timeout_hit) timeout_err <= 1'b1;
      end
   end

   assign state = cur_state;

`ifdef PLL_RESET_SEQ_RELOCK_CNT_EN
   logic       relock_hit;
   logic [7:0] relock_q;

   // Lock loss wins over a simultaneous soft_restart, so it still counts
   assign relock_hit = (cur_state == S_RUN) && !lk;

   always_ff @(posedge refclk) begin
      if (rst) begin
         relock_q <= 8'd0;
      end else if (relock_hit && (relock_q != 8'hFF)) begin
         relock_q <= relock_q + 8'd1;
      end
   end

   assign relock_cnt = relock_q;
`else
   assign relock_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized bench for pll_reset_sequencer against a cycle-level behavioural model.
// Model tracks time-in-state and a two-deep delay line for the lock synchronizer.
module tb_pll_reset_sequencer;

   localparam int HOLD_N = 4;
   localparam int TO_N   = 20;
   localparam int ST_N   = 8;

   logic       refclk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       soft_restart;
   logic       pll_rst;
   logic       core_rst;
   logic       ready;
   logic [1:0] state;
   logic       timeout_err;
   logic [7:0] relock_cnt;

   pll_reset_sequencer #(
      .RST_HOLD_CYCLES    (HOLD_N),
      .LOCK_TIMEOUT_CYCLES(TO_N),
      .LOCK_STABLE_CYCLES (ST_N),
      .CNT_W              (20)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .soft_restart(soft_restart),
      .pll_rst     (pll_rst),
      .core_rst    (core_rst),
      .ready       (ready),
      .state       (state),
      .timeout_err (timeout_err),
      .relock_cnt  (relock_cnt)
   );

   always #5 refclk = ~refclk;

   int n_checks = 0;
   int n_bad    = 0;

   // model: 0=HOLD 1=WAIT_LOCK 2=STABLE 3=RUN
   int m_state = 0;
   int m_age   = 0;
   int m_terr  = 0;
   int m_rc    = 0;
   bit m_d1    = 1'b0;
   bit m_d2    = 1'b0;
   int edges   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %0d want %0d", tag, edges, act, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit pl, input bit sr);
      bit lk_seen;
      int nxt;
      if (r) begin
         m_state = 0; m_age = 0; m_terr = 0; m_rc = 0;
         m_d1 = 1'b0; m_d2 = 1'b0;
         return;
      end
      lk_seen = m_d2;
      m_d2    = m_d1;
      m_d1    = pl;
      nxt     = m_state;
      if (m_state == 0) begin
         if (m_age + 1 >= HOLD_N) nxt = 1;
      end else if (m_state == 1) begin
         if (lk_seen) nxt = 2;
         else if (m_age + 1 >= TO_N) begin nxt = 0; m_terr = 1; end
      end else if (m_state == 2) begin
         if (!lk_seen) nxt = 1;
         else if (m_age + 1 >= ST_N) nxt = 3;
      end else begin
         if (!lk_seen) begin
            nxt  = 0;
            m_rc = (m_rc < 255) ? m_rc + 1 : 255;
         end else if (sr) nxt = 0;
      end
      m_age   = (nxt == m_state) ? m_age + 1 : 0;
      m_state = nxt;
   endtask

   task automatic check_outputs();
      int exp_rc;
`ifdef PLL_RESET_SEQ_RELOCK_CNT_EN
      exp_rc = m_rc;
`else
      exp_rc = 0;
`endif
      check_eq("state",       32'(state),       32'(m_state));
      check_eq("pll_rst",     32'(pll_rst),     32'(m_state == 0));
      check_eq("core_rst",    32'(core_rst),    32'(m_state != 3));
      check_eq("ready",       32'(ready),       32'(m_state == 3));
      check_eq("timeout_err", 32'(timeout_err), 32'(m_terr));
      check_eq("relock_cnt",  32'(relock_cnt),  32'(exp_rc));
   endtask

   task automatic tick(input bit r, input bit pl, input bit sr);
      rst          = r;
      pll_locked   = pl;
      soft_restart = sr;
      model_step(r, pl, sr);
      @(posedge refclk);
      #1;
      edges++;
      check_outputs();
   endtask

   initial begin
      int first_ready;
      int seg_left;
      bit seg_lvl;
      bit ok;

      rst = 1'b1; pll_locked = 1'b0; soft_restart = 1'b0;
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);

      // Power-up: pll_locked driven from edge 10 on; RUN expected after edge 10+2+ST_N
      edges = 0;
      first_ready = -1;
      for (int k = 1; k <= 40; k++) begin
         tick(1'b0, k >= 10, 1'b0);
         if (ready && first_ready < 0) first_ready = k;
      end
      check_eq("first_ready_edge", 32'(first_ready), 32'(10 + 2 + ST_N));

      // Lock never arrives: repeated timeouts
      for (int k = 0; k < 3 * (TO_N + HOLD_N) + 5; k++) tick(1'b0, 1'b0, 1'b0);
      check_eq("timeout_sticky", 32'(timeout_err), 32'd1);

      // Randomized segments of locked/unlocked, occasional soft_restart and rst
      seg_left = 0;
      seg_lvl  = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if (seg_left == 0) begin
            seg_lvl  = ~seg_lvl;
            seg_left = seg_lvl ? $urandom_range(1, 60) : $urandom_range(1, 30);
         end
         seg_left--;
         tick($urandom_range(0, 499) == 0, seg_lvl, $urandom_range(0, 15) == 0);
      end

      // Soft restart in WAIT_LOCK is ignored, in RUN it restarts
      tick(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < HOLD_N + 2; k++) tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      check_eq("sr_in_wait", 32'(state), 32'd1);
      ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
         tick(1'b0, 1'b1, 1'b0);
         ok = ready;
      end
      check_eq("reach_run_sr", 32'(ok), 32'd1);
      tick(1'b0, 1'b1, 1'b1);
      check_eq("sr_in_run", 32'(state), 32'd0);

      // Lock loss 300 times; relock_cnt saturates when the counter is built in
      tick(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 300; n++) begin
         ok = 1'b0;
         for (int k = 0; k < 80 && !ok; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            ok = ready;
         end
         if (!ok) check_eq("relock_wait", 32'(ok), 32'd1);
         for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0);
      end
`ifdef PLL_RESET_SEQ_RELOCK_CNT_EN
      check_eq("relock_sat", 32'(relock_cnt), 32'd255);
`else
      check_eq("relock_off", 32'(relock_cnt), 32'd0);
`endif

      // rst in STABLE clears everything including sticky flags
      for (int k = 0; k < TO_N + HOLD_N + 2; k++) tick(1'b0, 1'b0, 1'b0);
      ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
         tick(1'b0, 1'b1, 1'b0);
         ok = (state == 2'd2);
      end
      check_eq("reach_stable", 32'(ok), 32'd1);
      tick(1'b1, 1'b1, 1'b0);
      check_eq("rst_terr", 32'(timeout_err), 32'd0);
      check_eq("rst_rc",   32'(relock_cnt),  32'd0);
      check_eq("rst_state", 32'(state),      32'd0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
